// File: rtl/serial_sub_8.sv
`timescale 1ns/1ps
// serial_sub_8: bit-serial subtractor, D = A - B - Bor_in, one bit per clock,
// LSB first. An operation is accepted in IDLE on start, runs WIDTH bit steps
// in RUN, then spends one cycle in DONE with the done pulse high.
//
// Handshake: start is a request that is looked at only in IDLE; the edge that
// sees start=1 in IDLE captures A/B/Bor_in and begins the operation. busy is
// high exactly while bits are being processed (RUN). done is a one-cycle
// pulse coinciding with D/Bor_out having just been updated. Requests made
// while busy or during the done cycle are dropped, never queued.
module serial_sub_8 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bor_in,
   output logic [WIDTH-1:0] D,
   output logic             Bor_out,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] ar;
   logic [WIDTH-1:0] br;
   logic [WIDTH-1:0] res;
   logic             bor;
   logic [CW-1:0]    cnt;
   logic             d_bit;
   logic             bor_next;

   // One-bit full subtractor on the current LSBs and the running borrow.
   always_comb begin
      d_bit    = ar[0] ^ br[0] ^ bor;
      bor_next = (~ar[0] & br[0]) | (~(ar[0] ^ br[0]) & bor);
   end

   // busy is a pure decode of the state register, so it is glitch-free.
   assign busy = (state == S_RUN);

   // Control FSM plus operand/result shift registers; D and Bor_out only
   // update on the completion edge so they hold across IDLE and the next run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         ar      <= '0;
         br      <= '0;
         res     <= '0;
         bor     <= 1'b0;
         cnt     <= '0;
         D       <= '0;
         Bor_out <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  ar    <= A;
                  br    <= B;
                  bor   <= Bor_in;
                  cnt   <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               ar  <= ar >> 1;
               br  <= br >> 1;
               bor <= bor_next;
               res <= {d_bit, res[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  D       <= {d_bit, res[WIDTH-1:1]};
                  Bor_out <= bor_next;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_sub_8.sv
`timescale 1ns/1ps
// Bench for serial_sub_8: directed table, hand-written corner sequences
// (start while busy, asynchronous reset mid-run) and a random sweep checked
// against an integer-arithmetic reference model through an expected queue.
module tb_serial_sub_8;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Bor_in;
   logic [W-1:0] D;
   logic         Bor_out;
   logic         busy;
   logic         done;

   int vectors;
   int miscompares;

   // Expected {Bor_out, D} per operation, pushed at issue, popped at completion.
   logic [W:0] exp_q[$];

   // Expected D/Bor_out held from the last completed (or reset) operation.
   logic [W-1:0] last_d;
   logic         last_bo;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bi;
      logic [W-1:0] d;
      logic         bo;
   } vec_t;

   vec_t tbl[5];

   serial_sub_8 #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .A       (A),
      .B       (B),
      .Bor_in  (Bor_in),
      .D       (D),
      .Bor_out (Bor_out),
      .busy    (busy),
      .done    (done)
   );

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: plain signed integer subtraction.
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      int diff;
      logic [W-1:0] d;
      diff = int'(a) - int'(b) - int'(bi);
      d = W'(diff & ((1 << W) - 1));
      return {diff < 0, d};
   endfunction

   // Issue one operation and follow it to completion. inject_k > 0 pulses
   // start with A=B=0 for one cycle, k cycles after acceptance.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input logic [W-1:0] exp_d, input logic exp_bo,
                        input int inject_k, input string name);
      int busy_cnt;
      bit got;
      @(negedge clk);
      A = a; B = b; Bor_in = bi; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A = W'($urandom); B = W'($urandom); Bor_in = 1'($urandom);
      busy_cnt = busy ? 1 : 0;
      got = 1'b0;
      for (int k = 1; k <= W + 4 && !got; k++) begin
         @(posedge clk);
         #1;
         if (inject_k > 0 && k == inject_k) begin
            start = 1'b1; A = '0; B = '0;
         end else begin
            start = 1'b0;
         end
         if (k == 4) begin
            check({name, "_hold_d"}, 32'(D), 32'(last_d));
            check({name, "_hold_bo"}, 32'(Bor_out), 32'(last_bo));
         end
         if (busy) busy_cnt++;
         if (done) begin
            got = 1'b1;
            check({name, "_done_latency"}, 32'(k), 32'(W));
         end
      end
      start = 1'b0;
      if (!got) begin
         check({name, "_done_timeout"}, 32'(0), 32'(1));
      end
      check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
      check({name, "_d"}, 32'(D), 32'(exp_d));
      check({name, "_bor_out"}, 32'(Bor_out), 32'(exp_bo));
      last_d  = exp_d;
      last_bo = exp_bo;
      @(posedge clk);
      #1;
      check({name, "_after_done"}, 32'({busy, done}), 32'(0));
   endtask

   // Stimulus, checking and report.
   initial begin
      logic [W:0] e;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic rbi;
      int done_seen;

      vectors = 0;
      miscompares = 0;
      last_d = '0;
      last_bo = 1'b0;
      rst = 1'b1; start = 1'b0; A = '0; B = '0; Bor_in = 1'b0;

      tbl[0] = '{a: 8'h03, b: 8'h01, bi: 1'b0, d: 8'h02, bo: 1'b0};
      tbl[1] = '{a: 8'h00, b: 8'h01, bi: 1'b0, d: 8'hFF, bo: 1'b1};
      tbl[2] = '{a: 8'h05, b: 8'h05, bi: 1'b1, d: 8'hFF, bo: 1'b1};
      tbl[3] = '{a: 8'h00, b: 8'h00, bi: 1'b0, d: 8'h00, bo: 1'b0};
      tbl[4] = '{a: 8'h80, b: 8'h01, bi: 1'b0, d: 8'h7F, bo: 1'b0};

      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 32'({D, Bor_out, busy, done}), 32'(0));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         do_op(tbl[i].a, tbl[i].b, tbl[i].bi, tbl[i].d, tbl[i].bo, 0, $sformatf("tbl%0d", i));
      end

      // start pulsed while busy must be ignored
      do_op(8'hF0, 8'h0F, 1'b0, 8'hE1, 1'b0, 3, "start_in_busy");

      // asynchronous reset in the middle of a run
      @(negedge clk);
      A = 8'h55; B = 8'hAA; Bor_in = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_d", 32'(D), 32'(0));
      check("midrst_flags", 32'({Bor_out, busy, done}), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      last_d = '0;
      last_bo = 1'b0;
      done_seen = 0;
      for (int k = 0; k < W + 4; k++) begin
         @(posedge clk);
         #1;
         if (done) done_seen++;
      end
      check("midrst_no_done", 32'(done_seen), 32'(0));
      do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 0, "after_rst");

      // random sweep against the reference model
      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 5))
            0: ra = '0;
            1: ra = '1;
            default: ra = W'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: rb = '1;
            default: rb = W'($urandom);
         endcase
         rbi = 1'($urandom_range(0, 1));
         exp_q.push_back(model(ra, rb, rbi));
         e = exp_q.pop_front();
         do_op(ra, rb, rbi, e[W-1:0], e[W], 0, $sformatf("rnd%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/serial_sub_8.md
Name: serial_sub_8

Overview:
- Bit-serial subtractor. Computes D = A - B - Bor_in one bit per clock, LSB first.
- Start/busy/done handshake.
- Arithmetic inverse of the 8-bit ripple-carry adder. Trades area for latency where a full-width combinational path is not wanted.
- Serves as the reference subtractor that adder/subtractor benches check against.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be ≥2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  WIDTH  minuend; captured on the accepting edge
- B  input  WIDTH  subtrahend; captured on the accepting edge
- Bor_in  input  1  borrow-in; captured on the accepting edge
- D  output  WIDTH  difference; registered
- Bor_out  output  1  borrow-out (1 = A < B + Bor_in, unsigned); registered
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset:
  - rst high forces, asynchronously: state IDLE, D=0, Bor_out=0, busy=0, done=0.
  - Internal shift registers, borrow flop and bit counter are all cleared.
  - Reset mid-operation abandons the operation with no partial result.
  - After rst deasserts, the next edge with start=1 starts a fresh operation.
- States: IDLE, RUN, DONE. Two-bit encoding; the unused code goes to IDLE.
- IDLE:
  - busy=0.
  - Edge with start=1: capture A, B and Bor_in into internal registers, counter=0, go to RUN.
  - start=0: remain in IDLE.
- RUN:
  - busy=1.
  - Each edge processes bit a=Ar[0], b=Br[0], with bor the internal borrow:
    - d = a ^ b ^ bor
    - bor_next = (~a & b) | (~(a ^ b) & bor)
  - d shifts into the MSB of the internal result register. Ar and Br shift right by 1. counter increments.
  - On the edge where counter == WIDTH-1:
    - D <= completed result, with the final d in the MSB.
    - Bor_out <= bor_next.
    - done <= 1; go to DONE.
- DONE:
  - busy=0, done=1 for exactly this one cycle.
  - Next edge: done <= 0, go to IDLE, unconditionally.
- Latency:
  - done rises WIDTH edges after the edge that accepted start (8 for the default).
  - Minimum start-to-start spacing is WIDTH+2 edges.
- start is ignored in RUN and DONE. It is not queued. Holding start high in DONE starts a new operation on the first edge in IDLE.
- A, B and Bor_in may change freely after the accepting edge without affecting the result.
- D and Bor_out:
  - Change only on the completion edge (and on reset).
  - Hold their value through IDLE and through the next operation until that operation completes.
- Arithmetic:
  - Unsigned modulo 2^WIDTH: D = (A - B - Bor_in) mod 2^WIDTH.
  - Bor_out = 1 iff A < B + Bor_in.
  - For signed interpretation the caller derives overflow. No overflow output.

Test Plan:
- Reset, then A=8'h03, B=8'h01, Bor_in=0, start pulse:
  - busy high for 8 cycles.
  - done pulses once, 8 edges after start.
  - D=8'h02, Bor_out=0.
  - busy/done low the cycle after.
- A=8'h00, B=8'h01, Bor_in=0 -> D=8'hFF, Bor_out=1.
- A=8'h05, B=8'h05, Bor_in=1 -> D=8'hFF, Bor_out=1.
- A=8'h00, B=8'h00, Bor_in=0 -> D=8'h00, Bor_out=0.
- A=8'h80, B=8'h01, Bor_in=0 -> D=8'h7F, Bor_out=0.
- Start during busy and reset mid-operation:
  - Start A=8'hF0, B=8'h0F. Pulse start with A=8'h00 in cycle 3 -> ignored; result D=8'hE1, Bor_out=0.
  - Start again and assert rst asynchronously in cycle 4 -> D=0, Bor_out=0, busy=0, done never pulses.
  - After release, A=8'h10, B=8'h01 -> D=8'h0F.
- Exhaustive/random sweep of A, B and Bor_in against the reference model (A - B - Bor_in) mod 256 and borrow: zero mismatches.
